// File: rtl/bnn_weight_loader.sv
// Stages NUM_NEURONS host weight words, then on commit replays them as a gapless load_en burst.
// Latency: commit sampled at edge T -> load_en cycles T+1..T+NUM_NEURONS, done at T+NUM_NEURONS+1.
// Backpressure: wr_ready is high only while filling; a started burst always runs to completion.
// Optional feature macro: LOADER_PARITY_EN (even-parity check on each accepted host word).
module bnn_weight_loader #(
  parameter int NUM_NEURONS = 4,
  parameter int WEIGHT_W    = 6,
  localparam int CW = $clog2(NUM_NEURONS) + 1,
  localparam int IW = $clog2(NUM_NEURONS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [WEIGHT_W-1:0] wr_data,
  input  logic                wr_parity,
  input  logic                commit,
  input  logic                clear,
  output logic [CW-1:0]       fill_count,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                load_en,
  output logic [WEIGHT_W-1:0] load_data
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       fill_nxt;
  logic [IW-1:0]       idx, idx_nxt, idx_inc;
  logic                err_nxt;
  logic                load_en_nxt;
  logic [WEIGHT_W-1:0] load_data_nxt;
  logic                wbuf_we;
  logic                parity_bad;
  logic [WEIGHT_W-1:0] wbuf [NUM_NEURONS];

`ifdef LOADER_PARITY_EN
  // Even parity: data bits plus parity bit must hold an even number of ones.
  assign parity_bad = wr_parity ^ (^wr_data);
`else
  logic unused_parity;
  assign unused_parity = wr_parity;
  assign parity_bad    = 1'b0;
`endif

  assign wr_ready = (state == FILL);
  assign busy     = (state == SEND);
  assign done     = (state == DONE);
  assign idx_inc  = idx + 1'b1;

  // Next-state, counters, error flag and the next registered load strobe/data.
  always_comb begin
    state_nxt     = state;
    fill_nxt      = fill_count;
    idx_nxt       = idx;
    err_nxt       = err;
    load_en_nxt   = 1'b0;
    load_data_nxt = '0;
    wbuf_we       = 1'b0;
    case (state)
      FILL: begin
        if (clear) begin
          // Clear wins over a same-cycle write or commit; that word is dropped.
          fill_nxt = '0;
          err_nxt  = 1'b0;
        end else begin
          // Commit judged on the registered count, so it is early even if this write fills.
          if (commit) err_nxt = 1'b1;
          if (wr_valid) begin
            if (parity_bad) begin
              err_nxt = 1'b1;
            end else begin
              wbuf_we  = 1'b1;
              fill_nxt = fill_count + 1'b1;
              if (fill_count == CW'(NUM_NEURONS - 1)) state_nxt = ARMED;
            end
          end
        end
      end
      ARMED: begin
        if (clear) begin
          state_nxt = FILL;
          fill_nxt  = '0;
          err_nxt   = 1'b0;
        end else if (commit) begin
          state_nxt     = SEND;
          idx_nxt       = '0;
          load_en_nxt   = 1'b1;
          load_data_nxt = wbuf[0];
        end
      end
      SEND: begin
        // clear/commit ignored here: a burst is never truncated.
        if (idx == IW'(NUM_NEURONS - 1)) begin
          state_nxt = DONE;
        end else begin
          idx_nxt       = idx_inc;
          load_en_nxt   = 1'b1;
          load_data_nxt = wbuf[idx_inc];
        end
      end
      DONE: begin
        fill_nxt  = '0;
        state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // State and control registers; reset forces every output to idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      fill_count <= '0;
      idx        <= '0;
      err        <= 1'b0;
      load_en    <= 1'b0;
      load_data  <= '0;
    end else begin
      state      <= state_nxt;
      fill_count <= fill_nxt;
      idx        <= idx_nxt;
      err        <= err_nxt;
      load_en    <= load_en_nxt;
      load_data  <= load_data_nxt;
    end
  end

  // Staging buffer; contents are meaningless until refilled, so no reset.
  always_ff @(posedge clk) begin
    if (wbuf_we) wbuf[fill_count[IW-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_bnn_weight_loader.sv
// Directed bench for bnn_weight_loader: burst replay, early commit, back-pressure,
// clear/commit during a burst, reset mid-burst, and parity drop when enabled.
module tb_bnn_weight_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [5:0] wr_data;
  logic       wr_parity;
  logic       commit;
  logic       clear;
  logic [2:0] fill_count;
  logic       busy;
  logic       done;
  logic       err;
  logic       load_en;
  logic [5:0] load_data;

  int errors = 0;
  int checks = 0;

  bnn_weight_loader #(.NUM_NEURONS(4), .WEIGHT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_parity  (wr_parity),
    .commit     (commit),
    .clear      (clear),
    .fill_count (fill_count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .load_en    (load_en),
    .load_data  (load_data)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs observed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One accepted host write with correct even parity.
  task automatic write_word(input logic [5:0] d);
    wr_valid  = 1'b1;
    wr_data   = d;
    wr_parity = ^d;
    tick();
    wr_valid  = 1'b0;
  endtask

  // Commit, then verify the 4-word burst, the done pulse and the return to FILL.
  task automatic burst(input string tag, input logic [5:0] w0, input logic [5:0] w1,
                       input logic [5:0] w2, input logic [5:0] w3, input bit inject);
    logic [5:0] exp_w [4];
    exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_load_en"}, 32'(load_en), 32'd1);
      chk({tag, "_load_data"}, 32'(load_data), 32'(exp_w[i]));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_wr_ready_send"}, 32'(wr_ready), 32'd0);
      if (inject && i == 1) begin
        clear  = 1'b1;
        commit = 1'b1;
      end
      tick();
      clear  = 1'b0;
      commit = 1'b0;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_load_en_off"}, 32'(load_en), 32'd0);
    chk({tag, "_load_data_off"}, 32'(load_data), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_wr_ready_back"}, 32'(wr_ready), 32'd1);
    chk({tag, "_fill_zero"}, 32'(fill_count), 32'd0);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_parity = 1'b0;
    commit = 1'b0; clear = 1'b0;
    #12;
    chk("rst_fill", 32'(fill_count), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_load_en", 32'(load_en), 32'd0);
    chk("rst_load_data", 32'(load_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic burst.
    write_word(6'h38);
    chk("basic_fill1", 32'(fill_count), 32'd1);
    write_word(6'h07);
    write_word(6'h0C);
    chk("basic_fill3", 32'(fill_count), 32'd3);
    write_word(6'h33);
    chk("basic_fill4", 32'(fill_count), 32'd4);
    chk("basic_armed_rdy", 32'(wr_ready), 32'd0);
    chk("basic_armed_load_en", 32'(load_en), 32'd0);
    burst("basic", 6'h38, 6'h07, 6'h0C, 6'h33, 1'b0);
    chk("basic_err", 32'(err), 32'd0);

    // Early commit with 2 words buffered, then clear.
    write_word(6'h01);
    write_word(6'h02);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("early_err", 32'(err), 32'd1);
    chk("early_load_en", 32'(load_en), 32'd0);
    chk("early_fill", 32'(fill_count), 32'd2);
    chk("early_busy", 32'(busy), 32'd0);
    tick();
    chk("early_load_en2", 32'(load_en), 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_err", 32'(err), 32'd0);
    chk("clear_fill", 32'(fill_count), 32'd0);

    // Back-pressure: 5th word held while full, accepted as word 0 after the burst.
    write_word(6'h11);
    write_word(6'h22);
    write_word(6'h2A);
    write_word(6'h3F);
    wr_valid = 1'b1; wr_data = 6'h15; wr_parity = ^6'h15;
    tick();
    chk("bp_wr_ready", 32'(wr_ready), 32'd0);
    chk("bp_fill", 32'(fill_count), 32'd4);
    burst("bp", 6'h11, 6'h22, 6'h2A, 6'h3F, 1'b0);
    tick();
    wr_valid = 1'b0;
    chk("bp_accept", 32'(fill_count), 32'd1);
    write_word(6'h01);
    write_word(6'h02);
    write_word(6'h03);

    // Clear and commit on the 2nd burst cycle must not disturb the burst.
    burst("sendclr", 6'h15, 6'h01, 6'h02, 6'h03, 1'b1);
    chk("sendclr_err", 32'(err), 32'd0);

    // Reset on the 3rd load_en cycle.
    write_word(6'h0A);
    write_word(6'h0B);
    write_word(6'h0C);
    write_word(6'h0D);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    tick();
    chk("mid_load_en", 32'(load_en), 32'd1);
    chk("mid_load_data", 32'(load_data), 32'h0C);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_load_en", 32'(load_en), 32'd0);
    chk("mid_rst_load_data", 32'(load_data), 32'd0);
    chk("mid_rst_fill", 32'(fill_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    tick();
    write_word(6'h31);
    write_word(6'h32);
    write_word(6'h33);
    write_word(6'h34);
    burst("postrst", 6'h31, 6'h32, 6'h33, 6'h34, 1'b0);

`ifdef LOADER_PARITY_EN
    // Bad parity word is handshaken but dropped.
    wr_valid = 1'b1; wr_data = 6'h07; wr_parity = 1'b0;
    tick();
    wr_valid = 1'b0;
    chk("par_bad_err", 32'(err), 32'd1);
    chk("par_bad_fill", 32'(fill_count), 32'd0);
    wr_valid = 1'b1; wr_data = 6'h07; wr_parity = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("par_good_fill", 32'(fill_count), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("par_clear_err", 32'(err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
